// File: rtl/ring_check_pkg.sv
// Shared types and helpers for the ring pattern checker.
// Optional feature macro: RING_CHECK_AUTO_RELOCK_EN (see ring_pattern_checker.sv).
package ring_check_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      FAULT   = 2'd3
   } state_t;

   // Widest ring the rotate helper handles; instantiated widths must be below this.
   localparam int MAX_W  = 1024;
   localparam int IDX_W  = $clog2(MAX_W);

   // Position width for the default 100-bit ring.
   localparam int DEF_WIDTH = 100;
   localparam int POS_W     = $clog2(DEF_WIDTH);

   // Rotate the low w bits of word by one place; bits at and above w must be zero.
   // lr=0: right rotate (bit0 wraps to bit w-1); lr=1: left rotate (bit w-1 wraps to bit0).
   function automatic logic [MAX_W-1:0] rot(input logic [MAX_W-1:0] word,
                                            input int unsigned       w,
                                            input logic              lr);
      logic [MAX_W-1:0] r;
      logic [MAX_W-1:0] mask;
      logic [IDX_W-1:0] msb;
      msb  = IDX_W'(w - 1);
      mask = '1;
      mask = mask >> (MAX_W - w);
      if (lr) begin
         r    = (word << 1) & mask;
         r[0] = word[msb];
      end else begin
         r      = word >> 1;
         r[msb] = word[0];
      end
      return r;
   endfunction

endpackage

// File: rtl/ring_onehot_index.sv
// Combinational one-hot detector and hot-bit encoder for a ring word.
// For a non one-hot word the index is the OR of all set-bit positions (don't care).
module ring_onehot_index #(
   parameter int WIDTH = 100,
   parameter int POS_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] word_i,
   output logic             onehot_o,
   output logic [POS_W-1:0] index_o
);

   // Exactly one bit set, and its position.
   always_comb begin
      index_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (word_i[i]) index_o = index_o | POS_W'(i);
      end
      onehot_o = (word_i != '0) && ((word_i & (word_i - WIDTH'(1))) == '0);
   end

endmodule

// File: rtl/ring_pattern_checker.sv
// Receive-side ring counter checker: acquires lock on a rotating one-hot word,
// flywheels through errors once locked, and reports lock, error pulses,
// a saturating error count and the hot-bit position.
// Optional feature macro: RING_CHECK_AUTO_RELOCK_EN -- when defined, FAULT
// returns to ACQUIRE after one cycle; otherwise FAULT holds until check_en drops.
module ring_pattern_checker
   import ring_check_pkg::*;
#(
   parameter int WIDTH      = 100,
   parameter int ACQ_COUNT  = 4,
   parameter int LOSS_COUNT = 3,
   parameter int CNT_W      = 16,
   localparam int PW        = $clog2(WIDTH)
) (
   input  logic             clock0,
   input  logic             reset,
   input  logic             check_en,
   input  logic             lr,
   input  logic             pattern_valid,
   input  logic [WIDTH-1:0] pattern_in,
   output logic             locked,
   output logic             error_pulse,
   output logic [CNT_W-1:0] error_count,
   output logic [PW-1:0]    position,
   output logic             fault
);

   localparam int MW = $clog2(ACQ_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);
   localparam logic [MW-1:0] ACQ_LAST  = MW'(ACQ_COUNT - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);

   state_t            state_q;
   logic [WIDTH-1:0]  last_q;
   logic [MW-1:0]     match_q;
   logic [LW-1:0]     miss_q;
   logic              locked_q;
   logic              fault_q;
   logic              pulse_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [MAX_W-1:0]  rot_full;
   logic [WIDTH-1:0]  exp_word;
   logic [MAX_W-WIDTH-1:0] rot_unused;
   logic              in_onehot;
   logic [PW-1:0]     in_idx_unused;
   logic              last_onehot_unused;
   logic [PW-1:0]     last_idx;
   logic [CNT_W-1:0]  cnt_inc;

   // Predicted next word: last word rotated by the direction sampled with this word.
   always_comb begin
      rot_full   = rot(MAX_W'(last_q), WIDTH, lr);
      exp_word   = rot_full[WIDTH-1:0];
      rot_unused = rot_full[MAX_W-1:WIDTH];
   end

   ring_onehot_index #(.WIDTH(WIDTH), .POS_W(PW)) u_in_idx (
      .word_i   (pattern_in),
      .onehot_o (in_onehot),
      .index_o  (in_idx_unused)
   );

   // Once locked, last_q always holds the word the flywheel expected.
   ring_onehot_index #(.WIDTH(WIDTH), .POS_W(PW)) u_last_idx (
      .word_i   (last_q),
      .onehot_o (last_onehot_unused),
      .index_o  (last_idx)
   );

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   // Checker FSM with registered status outputs.
   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= '0;
         match_q  <= '0;
         miss_q   <= '0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         pulse_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pulse_q <= 1'b0;
         if (!check_en) begin
            // Disable wins over any word in the same cycle; error count is kept.
            state_q  <= IDLE;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= ACQUIRE;
                  cnt_q   <= '0;
                  last_q  <= '0;
                  match_q <= '0;
                  miss_q  <= '0;
               end
               ACQUIRE: begin
                  if (pattern_valid) begin
                     last_q <= pattern_in;
                     // A zeroed or non one-hot last word can never predict a match,
                     // so the first one-hot word only seeds the prediction.
                     if (in_onehot && (pattern_in == exp_word)) begin
                        if (match_q == ACQ_LAST) begin
                           state_q  <= LOCKED;
                           locked_q <= 1'b1;
                           match_q  <= '0;
                           miss_q   <= '0;
                        end else begin
                           match_q <= match_q + MW'(1);
                        end
                     end else begin
                        match_q <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (pattern_valid) begin
                     last_q <= exp_word;
                     if (pattern_in == exp_word) begin
                        miss_q <= '0;
                     end else begin
                        pulse_q <= 1'b1;
                        cnt_q   <= cnt_inc;
                        if (miss_q == LOSS_LAST) begin
                           state_q  <= FAULT;
                           locked_q <= 1'b0;
                           fault_q  <= 1'b1;
                           miss_q   <= '0;
                        end else begin
                           miss_q <= miss_q + LW'(1);
                        end
                     end
                  end
               end
               FAULT: begin
`ifdef RING_CHECK_AUTO_RELOCK_EN
                  // One-cycle fault pulse, then reacquire from scratch; count is kept.
                  state_q <= ACQUIRE;
                  fault_q <= 1'b0;
                  last_q  <= '0;
                  match_q <= '0;
                  miss_q  <= '0;
`else
                  // Parked until check_en drops; words are ignored.
                  state_q <= FAULT;
`endif
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign locked      = locked_q;
   assign fault       = fault_q;
   assign error_pulse = pulse_q;
   assign error_count = cnt_q;
   assign position    = locked_q ? last_idx : '0;

endmodule

// File: tb/tb_ring_pattern_checker.sv
// Directed bench for ring_pattern_checker (WIDTH=8, ACQ_COUNT=4, LOSS_COUNT=3).
// A second instance with CNT_W=2 shares the stimulus for the saturation case.
module tb_ring_pattern_checker;

   logic       clk;
   logic       rst;
   logic       en;
   logic       lr;
   logic       pv;
   logic [7:0] pin;

   logic        a_locked, a_pulse, a_fault;
   logic [15:0] a_cnt;
   logic [2:0]  a_pos;
   logic        s_locked, s_pulse, s_fault;
   logic [1:0]  s_cnt;
   logic [2:0]  s_pos;

   int errors = 0;
   int checks = 0;

   ring_pattern_checker #(.WIDTH(8), .ACQ_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut (
      .clock0(clk), .reset(rst), .check_en(en), .lr(lr), .pattern_valid(pv),
      .pattern_in(pin), .locked(a_locked), .error_pulse(a_pulse),
      .error_count(a_cnt), .position(a_pos), .fault(a_fault)
   );

   ring_pattern_checker #(.WIDTH(8), .ACQ_COUNT(4), .LOSS_COUNT(3), .CNT_W(2)) dut_s (
      .clock0(clk), .reset(rst), .check_en(en), .lr(lr), .pattern_valid(pv),
      .pattern_in(pin), .locked(s_locked), .error_pulse(s_pulse),
      .error_count(s_cnt), .position(s_pos), .fault(s_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One cycle with no valid word.
   task automatic cyc();
      @(negedge clk);
      pv = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // One valid word; outputs are sampled 1 time unit after the capturing edge.
   task automatic wr(input logic [7:0] w, input logic l);
      @(negedge clk);
      pv  = 1'b1;
      pin = w;
      lr  = l;
      @(posedge clk);
      #1;
      pv = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; lr = 1'b0; pv = 1'b0; pin = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", a_locked, 0);
      chk("rst_fault",  a_fault,  0);
      chk("rst_pulse",  a_pulse,  0);
      chk("rst_cnt",    a_cnt,    0);
      chk("rst_pos",    a_pos,    0);
      rst = 1'b0;
      en  = 1'b1;
      cyc();

      // Right rotate acquisition
      wr(8'h01, 0); wr(8'h80, 0); wr(8'h40, 0); wr(8'h20, 0);
      chk("r_not_yet", a_locked, 0);
      wr(8'h10, 0);
      chk("r_locked", a_locked, 1);
      chk("r_pos4",   a_pos,    4);
      chk("r_cnt0",   a_cnt,    0);
      wr(8'h08, 0);
      chk("r_pos3",   a_pos,    3);
      chk("r_nopulse", a_pulse, 0);

      // Single corruption: 0x03 instead of 0x04, flywheel continues with 0x02
      wr(8'h03, 0);
      chk("c_pulse",  a_pulse,  1);
      chk("c_cnt1",   a_cnt,    1);
      chk("c_locked", a_locked, 1);
      wr(8'h02, 0);
      chk("c_pulse_end", a_pulse, 0);
      chk("c_cnt_hold",  a_cnt,   1);
      chk("c_pos1",      a_pos,   1);
      cyc();
      chk("idle_pos", a_pos, 1);
      chk("idle_cnt", a_cnt, 1);

      // Disable keeps the count; re-enable clears it
      en = 1'b0;
      cyc();
      chk("dis_locked", a_locked, 0);
      chk("dis_cnt",    a_cnt,    1);
      chk("dis_pos",    a_pos,    0);
      en = 1'b1;
      cyc();
      chk("en_clr_cnt", a_cnt, 0);

      // Left rotate, then direction flip with a consistent word
      wr(8'h01, 1); wr(8'h02, 1); wr(8'h04, 1); wr(8'h08, 1); wr(8'h10, 1);
      chk("l_locked", a_locked, 1);
      chk("l_pos4",   a_pos,    4);
      wr(8'h08, 0);
      chk("flip_nopulse", a_pulse, 0);
      chk("flip_cnt0",    a_cnt,   0);
      chk("flip_pos3",    a_pos,   3);

      // Loss of lock: three wrong words (expected 0x04, 0x02, 0x01)
      wr(8'h00, 0); wr(8'h00, 0);
      chk("loss_cnt2",   a_cnt,    2);
      chk("loss_lock2",  a_locked, 1);
      chk("loss_fault2", a_fault,  0);
      wr(8'h00, 0);
      chk("loss_pulse",  a_pulse,  1);
      chk("loss_cnt3",   a_cnt,    3);
      chk("loss_fault",  a_fault,  1);
      chk("loss_unlock", a_locked, 0);
      chk("loss_pos0",   a_pos,    0);
`ifdef RING_CHECK_AUTO_RELOCK_EN
      cyc();
      chk("relock_fault_pulse", a_fault, 0);
      wr(8'h01, 0); wr(8'h80, 0); wr(8'h40, 0); wr(8'h20, 0);
      chk("relock_not_yet", a_locked, 0);
      wr(8'h10, 0);
      chk("relock_locked", a_locked, 1);
      chk("relock_cnt",    a_cnt,    3);
`else
      cyc();
      chk("fault_held", a_fault, 1);
      wr(8'h00, 0);
      chk("fault_no_count", a_cnt,   3);
      chk("fault_no_pulse", a_pulse, 0);
      chk("fault_still",    a_fault, 1);
`endif
      en = 1'b0;
      cyc();
      chk("fault_clear",  a_fault,  0);
      chk("fault_unlock", a_locked, 0);
      chk("fault_cnt",    a_cnt,    3);
      en = 1'b1;
      cyc();

      // Acquire robustness: junk before the seed
      wr(8'h00, 0); wr(8'h03, 0); wr(8'h01, 0);
      wr(8'h80, 0); wr(8'h40, 0); wr(8'h20, 0);
      chk("acq_not_yet", a_locked, 0);
      wr(8'h10, 0);
      chk("acq_locked", a_locked, 1);
      chk("acq_cnt0",   a_cnt,    0);

      // Disable beats a wrong word in the same cycle
      en = 1'b0;
      wr(8'h55, 0);
      chk("beat_pulse",  a_pulse,  0);
      chk("beat_locked", a_locked, 0);
      chk("beat_cnt",    a_cnt,    0);
      en = 1'b1;
      cyc();

      // Asynchronous reset mid-lock with a pulse in flight
      wr(8'h01, 0); wr(8'h80, 0); wr(8'h40, 0); wr(8'h20, 0); wr(8'h10, 0);
      wr(8'hFF, 0);
      chk("pre_rst_cnt",   a_cnt,   1);
      chk("pre_rst_pulse", a_pulse, 1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_locked", a_locked, 0);
      chk("arst_pulse",  a_pulse,  0);
      chk("arst_cnt",    a_cnt,    0);
      chk("arst_pos",    a_pos,    0);
      chk("arst_fault",  a_fault,  0);
      #2;
      rst = 1'b0;
      cyc();

      // Saturation: five isolated errors
      wr(8'h01, 0); wr(8'h80, 0); wr(8'h40, 0); wr(8'h20, 0); wr(8'h10, 0);
      chk("sat_locked_pre", s_locked, 1);
      wr(8'hFF, 0); wr(8'h04, 0);
      wr(8'hFF, 0); wr(8'h01, 0);
      wr(8'hFF, 0); wr(8'h40, 0);
      wr(8'hFF, 0); wr(8'h10, 0);
      wr(8'hFF, 0);
      chk("sat_cnt",    s_cnt,    3);
      chk("sat_pulse",  s_pulse,  1);
      chk("sat_locked", s_locked, 1);
      chk("wide_cnt5",  a_cnt,    5);
      chk("wide_locked", a_locked, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
